race_arbiter_n: RTL

Parametrised, registered N-channel race arbiter for the ring-oscillator PUF datapath. Once armed, it samples `NUM_CH` per-oscillator `finished` flags and latches the index of the first channel to assert. Simultaneous finishers are resolved to the lowest index and flagged as a tie. The result is held until it is acknowledged. It replaces the two-input combinational arbiter at the output of the oscillator counter bank and feeds the response-bit collector.

---
 rtl/race_arbiter_n.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/race_arbiter_n.sv
// race_arbiter_n
// Registered N-channel race arbiter for the ring-oscillator PUF datapath.
// After a start it watches the per-oscillator finished flags. It latches the
// lowest-indexed channel among those asserted in the first cycle that any
// flag is high. If more than one flag was high in that cycle, it also sets tie.
// The result is held in DONE until it is acknowledged.
//
// Optional feature macro: RACE_ARB_TIMEOUT_EN
//   defined   : ARMED aborts after TIMEOUT_CYCLES cycles with no finisher and
//               reports timeout=1.
//   undefined : no timeout counter, timeout is tied to 0, and ARMED waits
//               indefinitely.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   start       in   arm a new race (accepted only in IDLE)
//   ack         in   consume the held result (accepted only in DONE)
//   finished    in   [NUM_CH-1:0] level flags from the oscillator counters
//   busy        out  high while ARMED
//   done        out  high while DONE; winner/tie/timeout valid
//   winner      out  [IDX_W-1:0] index of the first finisher
//   winner_bit  out  1 iff winner==0 (legacy two-channel response bit)
//   tie         out  several channels asserted in the deciding cycle
//   timeout     out  race aborted with no finisher
module race_arbiter_n #(
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned IDX_W          = $clog2(NUM_CH),
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ack,
  input  logic [NUM_CH-1:0] finished,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  winner,
  output logic              winner_bit,
  output logic              tie,
  output logic              timeout
);

  // Elaboration-time parameter sanity.
  if (NUM_CH < 2 || NUM_CH > 64) begin : g_bad_num_ch
    $error("race_arbiter_n: NUM_CH must be in 2..64");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("race_arbiter_n: TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [IDX_W-1:0] winner_n;
  logic             tie_n;
  logic [IDX_W-1:0] first_idx;
  logic             any_fin;
  logic             multi_fin;

  // Lowest set index: scan downwards so the lowest set bit is written last.
  always_comb begin
    first_idx = '0;
    for (int unsigned i = NUM_CH; i > 0; i--) begin
      if (finished[i-1]) begin
        first_idx = IDX_W'(i - 1);
      end
    end
  end

  assign any_fin   = |finished;
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multi_fin = |(finished & (finished - NUM_CH'(1)));

`ifdef RACE_ARB_TIMEOUT_EN
  localparam logic [31:0] CNT_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] cnt;
  logic [31:0] cnt_n;
  logic        timeout_n;
`endif

  always_comb begin
    state_n  = state;
    winner_n = winner;
    tie_n    = tie;
`ifdef RACE_ARB_TIMEOUT_EN
    cnt_n     = cnt;
    timeout_n = timeout;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_n  = ARMED;
          winner_n = '0;
          tie_n    = 1'b0;
`ifdef RACE_ARB_TIMEOUT_EN
          cnt_n     = '0;
          timeout_n = 1'b0;
`endif
        end
      end
      ARMED: begin
        // A finisher takes precedence over an expiring timeout in the same cycle.
        if (any_fin) begin
          state_n  = DONE;
          winner_n = first_idx;
          tie_n    = multi_fin;
`ifdef RACE_ARB_TIMEOUT_EN
          timeout_n = 1'b0;
`endif
        end
`ifdef RACE_ARB_TIMEOUT_EN
        else if (cnt == CNT_LAST) begin
          state_n   = DONE;
          winner_n  = '0;
          tie_n     = 1'b0;
          timeout_n = 1'b1;
        end else begin
          cnt_n = cnt + 32'd1;
        end
`endif
      end
      DONE: begin
        if (ack) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      winner <= '0;
      tie    <= 1'b0;
    end else begin
      state  <= state_n;
      busy   <= (state_n == ARMED);
      done   <= (state_n == DONE);
      winner <= winner_n;
      tie    <= tie_n;
    end
  end

`ifdef RACE_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      timeout <= timeout_n;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign winner_bit = (winner == '0);

endmodule
